// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch prediction unit: counter encodings,
// PC geometry and the PC-to-table-index mapping.
package branch_predict_unit_pkg;

    localparam int PC_W        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_state_e;

    // Branch resolution bundle as it arrives from EX.
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            predict;
        logic            taken;
        logic [PC_W-1:0] target;
    } bp_ex_res_t;

    // Word-aligned PC bits above the byte offset select the entry; no tags.
    function automatic logic [PC_W-1:0] bp_index(input logic [PC_W-1:0] pc,
                                                 input int index_bits);
        return (pc >> $clog2(INSTR_BYTES)) & ((PC_W'(1) << index_bits) - PC_W'(1));
    endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// One 2-bit saturating prediction counter with load/inc/dec and a synchronous
// reset to a configurable initial state.
module bp_sat_counter2
    import branch_predict_unit_pkg::*;
#(
    parameter logic [1:0] INIT_STATE = WT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] state_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_o <= INIT_STATE;
        end else if (load_i) begin
            state_o <= load_val_i;
        end else if (inc_i && (state_o != ST)) begin
            state_o <= state_o + 2'd1;
        end else if (dec_i && (state_o != SNT)) begin
            state_o <= state_o - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// ID-stage branch predictor: PC-indexed table of 2-bit counters, EX-stage
// resolution with flush/redirect, and saturating performance counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         INDEX_BITS = 4,
    parameter logic [1:0] INIT_STATE = 2'b10,
    parameter int         CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      id_pc_i,
    input  logic             id_branch_i,
    output logic             predict_taken_o,
    input  logic             ex_branch_i,
    input  logic [31:0]      ex_pc_i,
    input  logic             ex_predict_i,
    input  logic             ex_taken_i,
    input  logic [31:0]      ex_target_i,
    output logic             mispredict_o,
    output logic             flush_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] branch_count_o,
    output logic [CNT_W-1:0] mispredict_count_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    bp_ex_res_t ex;
    assign ex = '{valid:   ex_branch_i,
                  pc:      ex_pc_i,
                  predict: ex_predict_i,
                  taken:   ex_taken_i,
                  target:  ex_target_i};

    logic [INDEX_BITS-1:0]    id_idx;
    logic [INDEX_BITS-1:0]    ex_idx;
    logic [ENTRIES-1:0][1:0]  pht;
    logic [ENTRIES-1:0]       hit;
    logic [1:0]               id_entry;

    assign id_idx = INDEX_BITS'(bp_index(id_pc_i, INDEX_BITS));
    assign ex_idx = INDEX_BITS'(bp_index(ex.pc, INDEX_BITS));

    // Reset wins inside each counter, so a reset cycle drops any training.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_pht
        assign hit[i] = ex.valid && (ex_idx == INDEX_BITS'(i));

        bp_sat_counter2 #(
            .INIT_STATE (INIT_STATE)
        ) u_ctr (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (1'b0),
            .load_val_i (2'b00),
            .inc_i      (hit[i] & ex.taken),
            .dec_i      (hit[i] & ~ex.taken),
            .state_o    (pht[i])
        );
    end

    // No bypass: a same-cycle update to this entry shows up next cycle.
    assign id_entry        = rst_i ? INIT_STATE : pht[id_idx];
    assign predict_taken_o = id_branch_i & (id_entry >= WT);

    assign mispredict_o  = ~rst_i & ex.valid & (ex.taken ^ ex.predict);
    assign flush_o       = mispredict_o;
    assign redirect_pc_o = !mispredict_o ? '0 :
                           ex.taken      ? ex.target :
                                           ex.pc + PC_W'(INSTR_BYTES);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_count_o     <= '0;
            mispredict_count_o <= '0;
        end else begin
            if (ex.valid && (branch_count_o != {CNT_W{1'b1}}))
                branch_count_o <= branch_count_o + CNT_W'(1);
            if (mispredict_o && (mispredict_count_o != {CNT_W{1'b1}}))
                mispredict_count_o <= mispredict_count_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed vector table, then reference-model
// driven sequences for saturation, mid-run reset and random traffic.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] id_pc;
    logic        id_br;
    logic        pred;
    logic        ex_br;
    logic [31:0] ex_pc;
    logic        ex_pred;
    logic        ex_taken;
    logic [31:0] ex_tgt;
    logic        mis;
    logic        flush;
    logic [31:0] redir;
    logic [3:0]  bcnt;
    logic [3:0]  mcnt;

    branch_predict_unit #(
        .INDEX_BITS (4),
        .INIT_STATE (2'b10),
        .CNT_W      (4)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .id_pc_i            (id_pc),
        .id_branch_i        (id_br),
        .predict_taken_o    (pred),
        .ex_branch_i        (ex_br),
        .ex_pc_i            (ex_pc),
        .ex_predict_i       (ex_pred),
        .ex_taken_i         (ex_taken),
        .ex_target_i        (ex_tgt),
        .mispredict_o       (mis),
        .flush_o            (flush),
        .redirect_pc_o      (redir),
        .branch_count_o     (bcnt),
        .mispredict_count_o (mcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        id_br;
        logic [31:0] id_pc;
        logic        ex_br;
        logic [31:0] ex_pc;
        logic        ex_pred;
        logic        ex_taken;
        logic [31:0] ex_tgt;
    } stim_t;

    typedef struct {
        logic        pred;
        logic        mis;
        logic [31:0] redir;
        logic [3:0]  bc;
        logic [3:0]  mc;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    exp_t  sb[$];
    vec_t  vecs[15];
    int    checks   = 0;
    int    failures = 0;
    int    mtbl[16];
    int    mbc;
    int    mmc;

    function automatic vec_t mkv(logic r, logic ib, logic [31:0] ipc,
                                 logic eb, logic [31:0] epc, logic ep, logic et,
                                 logic [31:0] etg, logic xp, logic xm,
                                 logic [31:0] xr, logic [3:0] xb, logic [3:0] xmc);
        vec_t v;
        v.s.rst = r;   v.s.id_br = ib;  v.s.id_pc = ipc;
        v.s.ex_br = eb; v.s.ex_pc = epc; v.s.ex_pred = ep;
        v.s.ex_taken = et; v.s.ex_tgt = etg;
        v.e.pred = xp; v.e.mis = xm; v.e.redir = xr; v.e.bc = xb; v.e.mc = xmc;
        return v;
    endfunction

    function automatic stim_t mks(logic r, logic ib, logic [31:0] ipc,
                                  logic eb, logic [31:0] epc, logic ep, logic et,
                                  logic [31:0] etg);
        stim_t s;
        s.rst = r; s.id_br = ib; s.id_pc = ipc; s.ex_br = eb; s.ex_pc = epc;
        s.ex_pred = ep; s.ex_taken = et; s.ex_tgt = etg;
        return s;
    endfunction

    function automatic int bidx(logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, req);
        end
    endtask

    // Drive one cycle at the falling edge, queue the expectation, then compare
    // the settled combinational outputs before the next rising edge.
    task automatic apply(input stim_t s, input exp_t e, input string tag);
        exp_t x;
        @(negedge clk);
        rst = s.rst; id_br = s.id_br; id_pc = s.id_pc;
        ex_br = s.ex_br; ex_pc = s.ex_pc; ex_pred = s.ex_pred;
        ex_taken = s.ex_taken; ex_tgt = s.ex_tgt;
        sb.push_back(e);
        #2;
        x = sb.pop_front();
        chk({tag, "_pred"},  32'(pred),  32'(x.pred));
        chk({tag, "_mis"},   32'(mis),   32'(x.mis));
        chk({tag, "_flush"}, 32'(flush), 32'(x.mis));
        chk({tag, "_redir"}, redir,      x.redir);
        chk({tag, "_bcnt"},  32'(bcnt),  32'(x.bc));
        chk({tag, "_mcnt"},  32'(mcnt),  32'(x.mc));
    endtask

    task automatic model_step(input stim_t s, input string tag);
        exp_t e;
        int   k;
        e.pred  = s.id_br & (s.rst ? 1'b1 : (mtbl[bidx(s.id_pc)] >= 2));
        e.mis   = ~s.rst & s.ex_br & (s.ex_taken != s.ex_pred);
        e.redir = !e.mis ? 32'h0 : (s.ex_taken ? s.ex_tgt : s.ex_pc + 32'd4);
        e.bc    = 4'(mbc);
        e.mc    = 4'(mmc);
        apply(s, e, tag);
        if (s.rst) begin
            foreach (mtbl[j]) mtbl[j] = 2;
            mbc = 0;
            mmc = 0;
        end else if (s.ex_br) begin
            k = bidx(s.ex_pc);
            if (s.ex_taken) begin
                if (mtbl[k] < 3) mtbl[k]++;
            end else if (mtbl[k] > 0) begin
                mtbl[k]--;
            end
            if (mbc < 15) mbc++;
            if (e.mis && mmc < 15) mmc++;
        end
    endtask

    initial begin
        rst = 1'b1; id_br = 1'b0; id_pc = '0; ex_br = 1'b0; ex_pc = '0;
        ex_pred = 1'b0; ex_taken = 1'b0; ex_tgt = '0;

        //           rst   idbr  id_pc         exbr  ex_pc          pred  taken ex_tgt        xpred xmis  xredir        bc    mc
        vecs[0]  = mkv(1'b1, 1'b1, 32'h40, 1'b1, 32'h40,       1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,   4'd0, 4'd0);
        vecs[1]  = mkv(1'b0, 1'b1, 32'h40, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,   4'd0, 4'd0);
        vecs[2]  = mkv(1'b0, 1'b1, 32'h40, 1'b1, 32'h40,       1'b1, 1'b0, 32'h200,  1'b1, 1'b1, 32'h44,  4'd0, 4'd0);
        vecs[3]  = mkv(1'b0, 1'b1, 32'h40, 1'b1, 32'h40,       1'b0, 1'b0, 32'h200,  1'b0, 1'b0, 32'h0,   4'd1, 4'd1);
        vecs[4]  = mkv(1'b0, 1'b1, 32'h40, 1'b1, 32'h40,       1'b0, 1'b0, 32'h200,  1'b0, 1'b0, 32'h0,   4'd2, 4'd1);
        vecs[5]  = mkv(1'b0, 1'b1, 32'h40, 1'b0, 32'h40,       1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   4'd3, 4'd1);
        vecs[6]  = mkv(1'b0, 1'b0, 32'h44, 1'b1, 32'h100,      1'b1, 1'b0, 32'h80,   1'b0, 1'b1, 32'h104, 4'd3, 4'd1);
        vecs[7]  = mkv(1'b0, 1'b1, 32'h44, 1'b1, 32'h100,      1'b0, 1'b1, 32'h80,   1'b1, 1'b1, 32'h80,  4'd4, 4'd2);
        vecs[8]  = mkv(1'b0, 1'b0, 32'h0,  1'b1, 32'h80,       1'b0, 1'b1, 32'h300,  1'b0, 1'b1, 32'h300, 4'd5, 4'd3);
        vecs[9]  = mkv(1'b0, 1'b1, 32'h40, 1'b1, 32'h80,       1'b1, 1'b0, 32'h10,   1'b1, 1'b1, 32'h84,  4'd6, 4'd4);
        vecs[10] = mkv(1'b0, 1'b1, 32'h40, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   4'd7, 4'd5);
        vecs[11] = mkv(1'b0, 1'b1, 32'h40, 1'b0, 32'h40,       1'b0, 1'b1, 32'h999,  1'b0, 1'b0, 32'h0,   4'd7, 4'd5);
        vecs[12] = mkv(1'b0, 1'b1, 32'h40, 1'b0, 32'h40,       1'b1, 1'b0, 32'h999,  1'b0, 1'b0, 32'h0,   4'd7, 4'd5);
        vecs[13] = mkv(1'b0, 1'b1, 32'h3C, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h1234, 1'b1, 1'b1, 32'h0,   4'd7, 4'd5);
        vecs[14] = mkv(1'b0, 1'b1, 32'h3C, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   4'd8, 4'd6);

        @(posedge clk);
        for (int i = 0; i < 15; i++)
            apply(vecs[i].s, vecs[i].e, $sformatf("v%0d", i));

        // Table state after the vectors: entries 0 and 15 trained to WNT.
        foreach (mtbl[j]) mtbl[j] = 2;
        mtbl[0]  = 1;
        mtbl[15] = 1;
        mbc = 8;
        mmc = 6;

        for (int i = 0; i < 12; i++)
            model_step(mks(1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0),
                       $sformatf("sat%0d", i));
        model_step(mks(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0), "sat_end");
        chk("sat_bcnt_hold", 32'(bcnt), 32'hF);
        chk("sat_mcnt_hold", 32'(mcnt), 32'hF);

        // Reset lands with a mispredicting branch that would otherwise train.
        model_step(mks(1'b1, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0, 1'b1, 32'h500), "midrst");
        for (int i = 0; i < 16; i++)
            model_step(mks(1'b0, 1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0),
                       $sformatf("post_rst%0d", i));
        chk("post_rst_bcnt", 32'(bcnt), 32'h0);

        for (int i = 0; i < 80; i++) begin
            stim_t s;
            s.rst      = ($urandom_range(0, 19) == 0);
            s.id_br    = 1'($urandom_range(0, 1));
            s.id_pc    = 32'($urandom_range(0, 63)) << 2;
            s.ex_br    = ($urandom_range(0, 3) != 0);
            s.ex_pc    = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                                     : 32'($urandom_range(0, 63)) << 2;
            s.ex_pred  = 1'($urandom_range(0, 1));
            s.ex_taken = 1'($urandom_range(0, 1));
            s.ex_tgt   = $urandom & 32'hFFFF_FFFC;
            model_step(s, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Sits in the ID stage, upstream of the ID/EX pipeline register.
- Holds a table of 2-bit saturating counters, indexed by PC, that predicts conditional branches; the predicted-taken bit feeds the ID/EX BranchPredict input.
- Receives branch resolution back from EX, trains the table, detects mispredictions, and drives the IF/ID and ID/EX flush plus the PC redirect.
- Keeps saturating performance counters for branches and mispredictions.

Parameters:
- INDEX_BITS, 4, log2 of table entries (16 entries); index = pc[INDEX_BITS+1:2].
- INIT_STATE, 2'b10, value loaded into every entry on reset (weakly taken).
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- id_pc_i  in  32  PC of the instruction in ID.
- id_branch_i  in  1  ID instruction is a conditional branch.
- predict_taken_o  out  1  prediction for the ID instruction; to ID/EX BranchPredict and the IF PC mux.
- ex_branch_i  in  1  EX instruction is a valid branch (ID/EX Branch output).
- ex_pc_i  in  32  PC of the EX branch.
- ex_predict_i  in  1  prediction carried through ID/EX.
- ex_taken_i  in  1  actual outcome resolved in EX.
- ex_target_i  in  32  branch target carried through ID/EX.
- mispredict_o  out  1  EX branch outcome differs from ex_predict_i.
- flush_o  out  1  flush request to IF/ID and ID/EX; equals mispredict_o.
- redirect_pc_o  out  32  correct next PC when mispredict_o=1: ex_taken_i ? ex_target_i : ex_pc_i+4. Otherwise 0.
- branch_count_o  out  CNT_W  number of EX-resolved branches since reset.
- mispredict_count_o  out  CNT_W  number of mispredictions since reset.

Behaviour:
- Reset: rst_i=1 at a rising edge loads every table entry with INIT_STATE and clears both counters.
  - While rst_i=1, mispredict_o, flush_o and redirect_pc_o are forced to 0 and no table update occurs.
  - predict_taken_o is combinational and reflects INIT_STATE[1] & id_branch_i.
  - A reset asserted mid-operation discards any pending training in that cycle.
- Lookup (0 cycles):
  - predict_taken_o = id_branch_i & table[id_pc_i[INDEX_BITS+1:2]][1].
  - Non-branches always read 0.
- Resolution (0 cycles, combinational on EX inputs):
  - mispredict_o = ex_branch_i & (ex_taken_i != ex_predict_i).
  - redirect_pc_o uses 32-bit wrap-around addition for ex_pc_i+4 (0xFFFF_FFFC+4 = 0).
- Training (1 cycle): at each rising edge with ex_branch_i=1 and rst_i=0, the entry at index ex_pc_i[INDEX_BITS+1:2] is updated.
  - Taken: 00->01->10->11; 11 stays 11.
  - Not taken: 11->10->01->00; 00 stays 00.
  - Entries not indexed hold their value.
- Same-index lookup and update in one cycle: no bypass. predict_taken_o uses the pre-edge value; the new value is visible from the next cycle.
- Aliasing: PCs sharing index bits share one entry. There are no tags.
- Counters:
  - branch_count_o increments on each edge with ex_branch_i=1.
  - mispredict_count_o increments on each edge with mispredict_o=1.
  - Both saturate at all-ones and never wrap.
- ex_branch_i=0: no training, no counter change, mispredict_o=0, regardless of the other EX inputs.
- The EX stage never holds a branch for more than one cycle, so each branch trains exactly once.

Decomposition:
- Shared package:
  - state encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - PC_W=32 and INSTR_BYTES=4;
  - the index-extraction function.
- Natural sub-module: bp_sat_counter2 (one 2-bit saturating counter with load/inc/dec, sync reset to INIT_STATE), instantiated per table entry.
- Counters and resolution logic stay in the top module.

Test Plan:
- Reset then lookup: rst_i=1 for 2 cycles, then id_branch_i=1, id_pc_i=0x40 -> predict_taken_o=1, counters=0, flush_o=0.
- Training to strong not-taken: three EX branches at 0x40 with ex_taken_i=0 and ex_predict_i matching the current prediction.
  - Entry goes 10->01->00->00.
  - mispredict_o=1 only on the first (predicted 1, actual 0).
  - Lookup at 0x40 then gives 0; mispredict_count_o=1, branch_count_o=3.
- Misprediction redirect:
  - ex_branch_i=1, ex_pc_i=0x100, ex_predict_i=1, ex_taken_i=0 -> flush_o=1, redirect_pc_o=0x104 in the same cycle.
  - With ex_predict_i=0, ex_taken_i=1, ex_target_i=0x80 -> redirect_pc_o=0x80.
- Same-index collision: ID looks up 0x40 while EX trains 0x80 (INDEX_BITS=4 gives index 0 for both) from 10 to 01 -> predict_taken_o=1 that cycle and 0 the next.
- Non-branch and wrap: ex_branch_i=0 with ex_taken_i toggling -> no table or counter change.
  - Mispredicted not-taken at ex_pc_i=0xFFFF_FFFC -> redirect_pc_o=0x0.
- Reset mid-run plus saturation:
  - Preload mispredict_count_o near all-ones (CNT_W=4 build) -> holds at 0xF.
  - Assert rst_i together with a mispredicting EX branch -> flush_o=0, all entries return to 10, counters to 0.
